// File: rtl/redirect_ctrl.sv
// rtl/redirect_ctrl.sv - prioritised redirect sequencer with predictor-update FIFO
// Optional statistics counters are enabled with REDIR_STATS_EN.
module redirect_ctrl #(
    parameter int PC_W      = 64,
    parameter int UPD_DEPTH = 4
`ifdef REDIR_STATS_EN
    ,
    parameter int CNT_W     = 32
`endif
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            ex_valid,
    input  logic            ex_is_cf,
    input  logic            ex_taken,
    input  logic [PC_W-1:0] ex_pc,
    input  logic            ex_pd_fail,
    input  logic [PC_W-1:0] ex_pc_correct,
    input  logic            cm_redirect,
    input  logic [PC_W-1:0] cm_target,
    output logic            redir_valid,
    output logic [PC_W-1:0] redir_pc,
    input  logic            redir_ready,
    output logic            flush,
    output logic            upd_valid,
    input  logic            upd_ready,
    output logic [PC_W-1:0] upd_pc,
    output logic [PC_W-1:0] upd_target,
    output logic            upd_taken,
    output logic            upd_drop
`ifdef REDIR_STATS_EN
    ,
    output logic [CNT_W-1:0] stat_cf,
    output logic [CNT_W-1:0] stat_mis
`endif
);
    localparam int AW = $clog2(UPD_DEPTH);

    localparam logic [0:0] IDLE = 1'b0;
    localparam logic [0:0] HOLD = 1'b1;

    logic [0:0]      state;
    logic            ex_fire;
    logic            mis;
    logic            push;
    logic            pop;
    logic            wr_en;
    logic            full;
    logic            empty;
    logic [AW:0]     wr_ptr;
    logic [AW:0]     rd_ptr;
    logic [PC_W-1:0] mem_pc    [UPD_DEPTH];
    logic [PC_W-1:0] mem_tgt   [UPD_DEPTH];
    logic            mem_taken [UPD_DEPTH];

    assign ex_fire = ex_valid & ex_is_cf;
    assign mis     = ex_fire & ex_pd_fail;

    // Only an instruction that survives (no older commit redirect, not wrong-path) is recorded.
    assign push  = ex_fire & (state == IDLE) & ~cm_redirect;
    assign empty = (wr_ptr == rd_ptr);
    assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign pop   = ~empty & upd_ready;
    assign wr_en = push & (~full | pop);

    assign redir_valid = (state == HOLD);
    assign upd_valid   = ~empty;
    assign upd_pc      = mem_pc[rd_ptr[AW-1:0]];
    assign upd_target  = mem_tgt[rd_ptr[AW-1:0]];
    assign upd_taken   = mem_taken[rd_ptr[AW-1:0]];

    // Commit redirect wins in either state; it also overrides a same-cycle acceptance.
    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= IDLE;
            redir_pc <= '0;
            flush    <= 1'b0;
        end else begin
            flush <= 1'b0;
            if (cm_redirect) begin
                state    <= HOLD;
                redir_pc <= cm_target;
                flush    <= 1'b1;
            end else if (state == IDLE && mis) begin
                state    <= HOLD;
                redir_pc <= ex_pc_correct;
                flush    <= 1'b1;
            end else if (state == HOLD && redir_ready) begin
                state <= IDLE;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            upd_drop <= 1'b0;
        end else begin
            upd_drop <= push & full & ~pop;
            if (wr_en) begin
                wr_ptr <= wr_ptr + {{AW{1'b0}}, 1'b1};
            end
            if (pop) begin
                rd_ptr <= rd_ptr + {{AW{1'b0}}, 1'b1};
            end
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem_pc[wr_ptr[AW-1:0]]    <= ex_pc;
            mem_tgt[wr_ptr[AW-1:0]]   <= ex_pc_correct;
            mem_taken[wr_ptr[AW-1:0]] <= ex_taken;
        end
    end

`ifdef REDIR_STATS_EN
    always_ff @(posedge clk) begin
        if (reset) begin
            stat_cf  <= '0;
            stat_mis <= '0;
        end else begin
            if (push) begin
                stat_cf <= stat_cf + {{(CNT_W-1){1'b0}}, 1'b1};
            end
            if (mis && state == IDLE && !cm_redirect) begin
                stat_mis <= stat_mis + {{(CNT_W-1){1'b0}}, 1'b1};
            end
        end
    end
`endif

endmodule
